// File: rtl/adc_scan_pkg.sv
// Shared definitions for the taxel ADC scan sequencer: FSM states, the timeout
// sentinel sample value and the counter-width helper.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_STORE
  } state_e;

  localparam int          DATA_W           = 16;
  localparam logic [15:0] TIMEOUT_SENTINEL = 16'h8000;

  // Bits needed for a down-counter that must hold max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_scan_seq_if.sv
// Handshake between the scan sequencer (master) and the ADC driver (slave).
interface adc_scan_seq_if;
  logic        adc_init_done;
  logic        adc_begin_conv;
  logic        adc_conv_done;
  logic [15:0] adc_conv_data;

  modport master (
    input  adc_init_done,
    input  adc_conv_done,
    input  adc_conv_data,
    output adc_begin_conv
  );

  modport slave (
    output adc_init_done,
    output adc_conv_done,
    output adc_conv_data,
    input  adc_begin_conv
  );
endinterface

// File: rtl/adc_scan_timer.sv
// Down-counter shared by mux settling and conversion timeout; o_expire marks
// the last counted cycle of a loaded interval.
module adc_scan_timer #(
  parameter int W = 16
) (
  input  logic         clk_50m,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = i_count && (r_cnt == W'(1));

endmodule

// File: rtl/adc_scan_seq.sv
// Taxel frame scanner: steps the analog mux over N_CH channels, settles,
// converts and emits one sample per channel. Define ADC_SCAN_AVG_EN to
// average two conversions per channel.
module adc_scan_seq
  import adc_scan_pkg::*;
#(
  parameter int N_CH        = 16,
  parameter int SETTLE_CYC  = 500,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                    clk_50m,
  input  logic                    rst_n,
  input  logic                    frame_start,
  adc_scan_seq_if.master          adc,
  output logic [$clog2(N_CH)-1:0] mux_sel,
  output logic                    sample_valid,
  output logic [$clog2(N_CH)-1:0] sample_ch,
  output logic [DATA_W-1:0]       sample_data,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = cnt_width(TMR_MAX);

  state_e            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_sample_ch;
  logic [DATA_W-1:0] r_sample_data;
  logic              r_begin_conv;
  logic              r_sample_valid;
  logic              r_frame_done;
  logic              r_busy;
  logic              r_err_timeout;

  logic              w_last_ch;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_count;
  logic              w_tmr_expire;

  assign w_last_ch = (r_ch == CH_W'(N_CH - 1));

  // Timer is reloaded in every state that precedes a timed state
  assign w_tmr_load  = (r_state == ST_IDLE) || (r_state == ST_START) || (r_state == ST_STORE);
  assign w_tmr_val   = (r_state == ST_START) ? TMR_W'(TIMEOUT_CYC) : TMR_W'(SETTLE_CYC);
  assign w_tmr_count = (r_state == ST_SETTLE) || (r_state == ST_WAIT);

  adc_scan_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_count    (w_tmr_count),
    .o_expire   (w_tmr_expire)
  );

`ifdef ADC_SCAN_AVG_EN
  logic               r_pass;
  logic [DATA_W-1:0]  r_first;
  logic signed [16:0] w_sum;
  logic [DATA_W-1:0]  w_avg;

  assign w_sum = $signed({r_first[15], r_first}) + $signed({adc.adc_conv_data[15], adc.adc_conv_data});
  assign w_avg = 16'(w_sum >>> 1);
`endif

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ch           <= '0;
      r_sample_ch    <= '0;
      r_sample_data  <= '0;
      r_begin_conv   <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_err_timeout  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      r_pass         <= 1'b0;
      r_first        <= '0;
`endif
    end else begin
      r_begin_conv   <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      // Losing the ADC driver mid-frame abandons the frame silently
      if ((r_state != ST_IDLE) && !adc.adc_init_done) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (frame_start && adc.adc_init_done) begin
              r_state       <= ST_SETTLE;
              r_ch          <= '0;
              r_busy        <= 1'b1;
              r_err_timeout <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
              r_pass        <= 1'b0;
`endif
            end
          end
          ST_SETTLE: begin
            if (w_tmr_expire) begin
              r_state      <= ST_START;
              r_begin_conv <= 1'b1;
            end
          end
          ST_START: begin
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (adc.adc_conv_done) begin
`ifdef ADC_SCAN_AVG_EN
              if (!r_pass) begin
                r_first      <= adc.adc_conv_data;
                r_pass       <= 1'b1;
                r_state      <= ST_START;
                r_begin_conv <= 1'b1;
              end else begin
                r_sample_data  <= w_avg;
                r_state        <= ST_STORE;
                r_sample_valid <= 1'b1;
                r_sample_ch    <= r_ch;
                r_frame_done   <= w_last_ch;
              end
`else
              r_sample_data  <= adc.adc_conv_data;
              r_state        <= ST_STORE;
              r_sample_valid <= 1'b1;
              r_sample_ch    <= r_ch;
              r_frame_done   <= w_last_ch;
`endif
            end else if (w_tmr_expire) begin
              r_err_timeout  <= 1'b1;
              r_sample_data  <= TIMEOUT_SENTINEL;
              r_state        <= ST_STORE;
              r_sample_valid <= 1'b1;
              r_sample_ch    <= r_ch;
              r_frame_done   <= w_last_ch;
            end
          end
          ST_STORE: begin
`ifdef ADC_SCAN_AVG_EN
            r_pass <= 1'b0;
`endif
            if (w_last_ch) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ch    <= r_ch + CH_W'(1);
              r_state <= ST_SETTLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc.adc_begin_conv = r_begin_conv;
  assign mux_sel            = r_ch;
  assign sample_valid       = r_sample_valid;
  assign sample_ch          = r_sample_ch;
  assign sample_data        = r_sample_data;
  assign frame_done         = r_frame_done;
  assign busy               = r_busy;
  assign err_timeout        = r_err_timeout;

endmodule

// File: tb/tb_adc_scan_seq.sv
// Randomized bench for adc_scan_seq: ADC driver model plus a sample scoreboard
// derived from frame/channel rules (conversion queue, expected latency).
module tb_adc_scan_seq;

  localparam int N_CH        = 4;
  localparam int CH_W        = 2;
  localparam int SETTLE_CYC  = 10;
  localparam int TIMEOUT_CYC = 100;
  localparam int CONV_LAT    = 40;
  localparam int HANG_CH     = 2;
`ifdef ADC_SCAN_AVG_EN
  localparam int          PASSES  = 2;
  localparam logic [15:0] DIR_A   = 16'h0002;
  localparam logic [15:0] DIR_B   = 16'hFFFC;
  localparam logic [15:0] DIR_EXP = 16'hFFFF;
`else
  localparam int          PASSES  = 1;
  localparam logic [15:0] DIR_A   = 16'h1234;
  localparam logic [15:0] DIR_B   = 16'h1234;
  localparam logic [15:0] DIR_EXP = 16'h1234;
`endif
  localparam int PER_CH = SETTLE_CYC + PASSES * (1 + CONV_LAT) + 1;
  localparam int FRAME_BUDGET = N_CH * (SETTLE_CYC + PASSES * (TIMEOUT_CYC + 1) + 1) + 50;

  logic            clk_50m = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_start = 1'b0;
  logic [CH_W-1:0] mux_sel;
  logic            sample_valid;
  logic [CH_W-1:0] sample_ch;
  logic [15:0]     sample_data;
  logic            frame_done;
  logic            busy;
  logic            err_timeout;

  adc_scan_seq_if adc();

  adc_scan_seq #(
    .N_CH        (N_CH),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .adc          (adc),
    .mux_sel      (mux_sel),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .frame_done   (frame_done),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic [15:0] d;
  } conv_t;

  conv_t conv_q[$];
  bit    hang_en  = 1'b0;
  bit    force_en = 1'b0;
  bit    stray_en = 1'b0;
  int    conv_idx = 0;
  int    begin_cnt = 0;
  int    samp_cnt = 0;
  int    fd_cnt = 0;
  int    fd_cyc = 0;
  int    exp_ch = 0;
  int    start_cyc = 0;

  // ADC driver model: done pulse CONV_LAT cycles after begin_conv, stray pulses when idle
  int          a_cd = 0;
  int          a_ch = 0;
  logic [15:0] a_d;
  conv_t       a_new;
  initial begin
    adc.adc_conv_done = 1'b0;
    adc.adc_conv_data = 16'h0000;
    forever begin
      @(negedge clk_50m);
      adc.adc_conv_done = 1'b0;
      if (!rst_n) begin
        a_cd = 0;
      end else begin
        if (a_cd > 0) begin
          a_cd--;
          if (a_cd == 0) begin
            if (force_en) a_d = (conv_idx % 2 == 0) ? DIR_A : DIR_B;
            else          a_d = 16'($urandom);
            conv_idx++;
            adc.adc_conv_done = 1'b1;
            adc.adc_conv_data = a_d;
            a_new.ch = a_ch;
            a_new.d  = a_d;
            conv_q.push_back(a_new);
          end
        end else if (stray_en && !hang_en && ($urandom_range(0, 7) == 0)) begin
          adc.adc_conv_done = 1'b1;
          adc.adc_conv_data = 16'hDEAD;
        end
        if (adc.adc_begin_conv) begin
          begin_cnt++;
          a_ch = int'(mux_sel);
          if (!(hang_en && (int'(mux_sel) == HANG_CH))) a_cd = CONV_LAT;
        end
      end
    end
  end

  // Sample scoreboard
  int          m_n;
  logic [15:0] m_a, m_b, m_exp;
  conv_t       m_e;
  always @(negedge clk_50m) begin
    if (rst_n && sample_valid) begin
      m_n = 0;
      m_a = 16'h0;
      m_b = 16'h0;
      while (conv_q.size() > 0 && conv_q[0].ch == exp_ch) begin
        m_e = conv_q.pop_front();
        if (m_n == 0) m_a = m_e.d;
        else          m_b = m_e.d;
        m_n++;
      end
      if (hang_en && exp_ch == HANG_CH) begin
        m_exp = 16'h8000;
      end else begin
        check("conv_count", 32'(m_n), 32'(PASSES));
`ifdef ADC_SCAN_AVG_EN
        m_exp = 16'((int'($signed(m_a)) + int'($signed(m_b))) >>> 1);
`else
        m_exp = m_a;
`endif
      end
      $display("sample ch=%0d data=0x%04h exp=0x%04h frame_done=%0d", sample_ch, sample_data, m_exp, frame_done);
      check("sample_ch", 32'(sample_ch), 32'(exp_ch));
      check("sample_data", 32'(sample_data), 32'(m_exp));
      check("frame_done_align", 32'(frame_done), 32'(exp_ch == N_CH - 1));
      samp_cnt++;
      exp_ch = (exp_ch + 1) % N_CH;
    end
    if (rst_n && frame_done) begin
      if (!sample_valid) check("frame_done_alone", 32'(sample_valid), 32'd1);
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic pulse_start();
    @(negedge clk_50m);
    frame_start = 1'b1;
    start_cyc   = cyc + 1;
    exp_ch      = 0;
    conv_idx    = 0;
    @(negedge clk_50m);
    frame_start = 1'b0;
  endtask

  task automatic raw_start();
    @(negedge clk_50m);
    frame_start = 1'b1;
    @(negedge clk_50m);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int  n0;
    bit  ok;
    n0 = fd_cnt;
    ok = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk_50m);
      if (fd_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_sample_ch"}, 32'(sample_ch), 32'd0);
    check({tag, "_sample_data"}, 32'(sample_data), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, "_begin_conv"}, 32'(adc.adc_begin_conv), 32'd0);
  endtask

  int s0, f0, b0;
  bit found;

  initial begin
    adc.adc_init_done = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Directed data frame with exact latency
    force_en = 1'b1;
    s0 = samp_cnt; b0 = begin_cnt;
    pulse_start();
    check("dir_busy", 32'(busy), 32'd1);
    wait_frame("dir");
    check("dir_latency", 32'(fd_cyc - start_cyc), 32'(N_CH * PER_CH - 1));
    check("dir_samples", 32'(samp_cnt - s0), 32'(N_CH));
    check("dir_begins", 32'(begin_cnt - b0), 32'(N_CH * PASSES));
    check("dir_last_data", 32'(sample_data), 32'(DIR_EXP));
    tick(2);
    check("dir_idle", 32'(busy), 32'd0);
    force_en = 1'b0;

    // Random data frames with stray done pulses
    stray_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      s0 = samp_cnt;
      pulse_start();
      wait_frame("rnd");
      check("rnd_latency", 32'(fd_cyc - start_cyc), 32'(N_CH * PER_CH - 1));
      check("rnd_samples", 32'(samp_cnt - s0), 32'(N_CH));
      tick($urandom_range(1, 20));
    end

    // frame_start while busy is ignored
    s0 = samp_cnt; b0 = begin_cnt;
    pulse_start();
    tick(30);
    raw_start();
    wait_frame("busy");
    tick(300);
    check("busy_samples", 32'(samp_cnt - s0), 32'(N_CH));
    check("busy_begins", 32'(begin_cnt - b0), 32'(N_CH * PASSES));
    check("busy_idle", 32'(busy), 32'd0);

    // frame_start without adc_init_done is ignored
    adc.adc_init_done = 1'b0;
    tick(2);
    b0 = begin_cnt;
    raw_start();
    tick(50);
    check("noinit_busy", 32'(busy), 32'd0);
    check("noinit_begins", 32'(begin_cnt - b0), 32'd0);
    adc.adc_init_done = 1'b1;
    tick(2);

    // Channel 2 never completes: timeout sentinel, sticky error, frame finishes
    stray_en = 1'b0;
    hang_en  = 1'b1;
    s0 = samp_cnt;
    pulse_start();
    wait_frame("hang");
    check("hang_samples", 32'(samp_cnt - s0), 32'(N_CH));
    check("hang_err", 32'(err_timeout), 32'd1);
    hang_en = 1'b0;
    tick(5);
    check("hang_err_sticky", 32'(err_timeout), 32'd1);
    pulse_start();
    check("err_cleared", 32'(err_timeout), 32'd0);
    wait_frame("after_hang");

    // Asynchronous reset during WAIT of channel 1
    tick(3);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < FRAME_BUDGET; i++) begin
      @(negedge clk_50m);
      if (adc.adc_begin_conv && mux_sel == CH_W'(1)) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_found_ch1", 32'(found), 32'd1);
    tick(10);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    conv_q.delete();
    tick(2);
    rst_n = 1'b1;
    s0 = samp_cnt; f0 = fd_cnt; b0 = begin_cnt;
    tick(300);
    check("midrst_samples", 32'(samp_cnt - s0), 32'd0);
    check("midrst_frames", 32'(fd_cnt - f0), 32'd0);
    check("midrst_begins", 32'(begin_cnt - b0), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);

    // adc_init_done drop during SETTLE aborts the frame
    f0 = fd_cnt; b0 = begin_cnt;
    pulse_start();
    tick(3);
    adc.adc_init_done = 1'b0;
    tick(1);
    check("abort_idle", 32'(busy), 32'd0);
    tick(100);
    check("abort_frames", 32'(fd_cnt - f0), 32'd0);
    check("abort_begins", 32'(begin_cnt - b0), 32'd0);
    adc.adc_init_done = 1'b1;
    tick(2);

    // Recovery frame
    s0 = samp_cnt;
    pulse_start();
    wait_frame("recover");
    check("recover_samples", 32'(samp_cnt - s0), 32'(N_CH));
    check("recover_latency", 32'(fd_cyc - start_cyc), 32'(N_CH * PER_CH - 1));

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
